// File: rtl/stepper_pkg.sv
// Shared types and default timing constants for the stepper pulse path.
package stepper_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } state_e;

  localparam int unsigned DefPulseWidth = 16;
  localparam int unsigned DefDirSetup   = 4;

endpackage

// File: rtl/step_pulse_gen_if.sv
// Move request and driver-side status bundle between the register bank and step_pulse_gen.
interface step_pulse_gen_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic                  stop;
  logic                  dir_in;
  logic [DATA_WIDTH-1:0] steps_in;
  logic [DATA_WIDTH-1:0] period_in;
  logic                  step_out;
  logic                  dir_out;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] remaining;

  modport master (
    output start, stop, dir_in, steps_in, period_in,
    input  step_out, dir_out, busy, done, remaining
  );

  modport slave (
    input  start, stop, dir_in, steps_in, period_in,
    output step_out, dir_out, busy, done, remaining
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter; tc_o marks the last cycle of a phase loaded with (length - 1).
module phase_timer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: DIR setup delay, then a bounded train of fixed-width STEP pulses.
module step_pulse_gen
  import stepper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PULSE_WIDTH = DefPulseWidth,
  parameter int unsigned DIR_SETUP   = DefDirSetup
) (
  input  logic             clk_in,
  input  logic             rst_in,
  step_pulse_gen_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] PwW       = DATA_WIDTH'(PULSE_WIDTH);
  localparam logic [DATA_WIDTH-1:0] PwLoad    = DATA_WIDTH'(PULSE_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] SetupLoad = DATA_WIDTH'(DIR_SETUP - 1);

  state_e                state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  step_q, step_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] low_len_q, low_len_d;
  logic [DATA_WIDTH-1:0] eff_period;
  logic                  tmr_load;
  logic [DATA_WIDTH-1:0] tmr_val;
  logic                  tmr_tc;

  // Clamp keeps at least one low clock between pulses.
  assign eff_period = (bus.period_in > PwW) ? bus.period_in : PwW + DATA_WIDTH'(1);

  phase_timer #(
    .Width (DATA_WIDTH)
  ) u_phase_timer (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rem_d       = rem_q;
    low_len_d   = low_len_q;
    stop_pend_d = stop_pend_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (bus.start) begin
          if (bus.steps_in != '0) begin
            state_d   = StSetup;
            dir_d     = bus.dir_in;
            busy_d    = 1'b1;
            rem_d     = bus.steps_in;
            low_len_d = eff_period - PwW;
            tmr_load  = 1'b1;
            tmr_val   = SetupLoad;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StSetup: begin
        // No pulse has started yet, so an abort here is clean and immediate.
        if (bus.stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (tmr_tc) begin
          state_d  = StHigh;
          rem_d    = rem_q - DATA_WIDTH'(rem_q != '0);
          tmr_load = 1'b1;
          tmr_val  = PwLoad;
        end
      end
      StHigh: begin
        if (bus.stop) begin
          stop_pend_d = 1'b1;
        end
        if (tmr_tc) begin
          state_d  = StLow;
          tmr_load = 1'b1;
          tmr_val  = low_len_q - DATA_WIDTH'(1);
        end
      end
      StLow: begin
        if (bus.stop) begin
          stop_pend_d = 1'b1;
        end
        if (tmr_tc) begin
          if (rem_q == '0 || stop_pend_q || bus.stop) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d  = StHigh;
            rem_d    = rem_q - DATA_WIDTH'(1);
            tmr_load = 1'b1;
            tmr_val  = PwLoad;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    step_d = (state_d == StHigh);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      rem_q       <= '0;
      low_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_q      <= step_d;
      stop_pend_q <= stop_pend_d;
      rem_q       <= rem_d;
      low_len_q   <= low_len_d;
    end
  end

  assign bus.step_out  = step_q;
  assign bus.dir_out   = dir_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Step/direction pulse generator for the stepper driver. It consumes the motion parameters held in the memory-mapped register bank (step count, step period, direction) and emits a bounded train of STEP pulses with a DIR line to the external motor driver IC. Software writes the registers, then pulses `start`. The block reports progress through `busy`, `done` and `remaining`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the count and period inputs and of `remaining`.
- `PULSE_WIDTH`, 16: number of clocks that STEP is high per pulse, minimum 1.
- `DIR_SETUP`, 4: number of clocks from the DIR change to the first STEP rise, minimum 1.

Ports:
- `clk_in` input 1: system clock; all logic is on the rising edge.
- `rst_in` input 1: reset, synchronous and active-high.
- `start` input 1: one-cycle request to begin a move.
- `stop` input 1: request to abort after the current pulse.
- `dir_in` input 1: requested direction; 1 means forward.
- `steps_in` input DATA_WIDTH: number of steps in the move.
- `period_in` input DATA_WIDTH: clocks per step, measured rise to rise.
- `step_out` output 1: STEP line to the driver.
- `dir_out` output 1: DIR line to the driver.
- `busy` output 1: high from acceptance of a move until `done`.
- `done` output 1: one-cycle pulse at the end of a move or an abort.
- `remaining` output DATA_WIDTH: number of steps not yet started.

## Operation
- Reset values: `step_out`=0, `dir_out`=0, `busy`=0, `done`=0, `remaining`=0, state IDLE, all counters 0.
- States: IDLE, SETUP, HIGH, LOW.
- IDLE:
  - `start`=1 and `steps_in`≠0: latch `steps_in`, `dir_in` and the effective period, set `dir_out`, set `busy`, go to SETUP.
  - `start`=1 and `steps_in`=0: pulse `done` on the next cycle and stay in IDLE. `dir_out` is unchanged.
- Effective period = max(`period_in`, `PULSE_WIDTH`+1), so the low phase is always at least 1 clock.
- SETUP: lasts `DIR_SETUP` cycles, then go to HIGH.
- HIGH:
  - `step_out`=1 for `PULSE_WIDTH` cycles.
  - `remaining` decrements by 1 on entry to HIGH.
  - Then go to LOW.
- LOW:
  - `step_out`=0 for (effective period − `PULSE_WIDTH`) cycles.
  - On exit: if `remaining`=0 or a stop is pending, pulse `done`, clear `busy` and go to IDLE. Otherwise go to HIGH.
- `stop`:
  - Sampled in any non-IDLE state and held as pending.
  - In SETUP: go to IDLE immediately, `done` pulses, no STEP is emitted, and `remaining` keeps the latched count.
  - In HIGH or LOW: the current pulse completes in full (no runt pulses), then the block aborts.
  - Ignored in IDLE.
- `start` while `busy` is ignored; the latched parameters must not change mid-move.
- `start` and `stop` in the same IDLE cycle: `start` wins and `stop` is ignored.
- `rst_in` mid-move: all outputs take their reset values on the next edge. `step_out` falls immediately, even mid-pulse.
- Arithmetic: unsigned, DATA_WIDTH bits. `remaining` never underflows.

## Timing
- `start` sampled at edge N → `busy`=1 and `dir_out` valid after edge N.
- First `step_out` rise after edge N+`DIR_SETUP`.
- STEP rise-to-rise equals the effective period exactly. There are no idle gaps between steps.
- Total move time: `DIR_SETUP` + `steps_in` × effective period clocks from acceptance to the `done` cycle.
- `done` is high for exactly one cycle. `busy` falls in the same cycle that `done` rises.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `stepper_pkg`:
  - state enum (IDLE/SETUP/HIGH/LOW),
  - default constants for `PULSE_WIDTH` and `DIR_SETUP`.
- The register bank connects to this block by wiring register outputs to `steps_in`, `period_in` and `dir_in`.
- One sub-module, `phase_timer`: a loadable down-counter with a terminal-count flag. It times SETUP, HIGH and LOW.

## Test plan
- Reset, then `steps_in`=3, `period_in`=40, `dir_in`=1, `start` → `dir_out`=1, 3 pulses each 16 cycles high and 40 cycles rise to rise, first rise 4 cycles after start, `done` at cycle 124, `remaining`=0.
- `period_in`=5 with `PULSE_WIDTH`=16 → effective period 17: 16 cycles high, 1 cycle low.
- `steps_in`=0, `start` → `done` one cycle later, no STEP activity, `busy` stays 0.
- `steps_in`=10, `stop` asserted midway through the 4th HIGH phase → 4th pulse completes at full width, `done` fires after its LOW phase, `remaining`=6.
- `start` with `steps_in`=5, then a second `start` with `steps_in`=99 while busy → exactly 5 pulses. Then `rst_in` during a new move's HIGH phase → `step_out`=0, `busy`=0 and `remaining`=0 on the next edge.
